// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared fetch definitions: state encoding, opcode field layout and ROM geometry defaults.
package rom_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam int          ROM_AW_DEF  = 8;
    localparam int          ROM_DW_DEF  = 26;
    localparam int          OP_W        = 5;
    localparam int          OP_LSB_DEF  = 20;
    localparam logic [4:0]  OP_EXIT     = 5'h1F;

endpackage

// File: rtl/rom_fetch_ctrl_fetch_pc.sv
// Program counter: load has priority over increment; the wrap flag is sticky until cleared.
module fetch_pc #(
    parameter int              AW       = 8,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    input  logic          clr_wrap_i,
    output logic [AW-1:0] pc_o,
    output logic          wrapped_o
);

    logic [AW-1:0] pc_q;
    logic          wrap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            wrap_q <= 1'b0;
        end else begin
            if (load_i) begin
                pc_q <= load_val_i;
            end else if (inc_i) begin
                pc_q <= pc_q + AW'(1);
            end
            // a redirect load never sets the flag, only a real increment past the top
            if (clr_wrap_i) begin
                wrap_q <= 1'b0;
            end else if (inc_i && !load_i && (pc_q == {AW{1'b1}})) begin
                wrap_q <= 1'b1;
            end
        end
    end

    assign pc_o      = pc_q;
    assign wrapped_o = wrap_q;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers ROM words and offers them over valid/ready.
// state | meaning
// IDLE  | waiting for start
// FETCH | reading ROM at pc, instruction register empty
// ISSUE | instruction offered (inst_valid=1), refilled back-to-back on accept
// HALT  | EXIT consumed, fetch frozen until start
module rom_fetch_ctrl
    import rom_fetch_ctrl_pkg::*;
#(
    parameter int              AW       = ROM_AW_DEF,
    parameter int              DW       = ROM_DW_DEF,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              OP_LSB   = OP_LSB_DEF,
    parameter logic [4:0]      HALT_OP  = OP_EXIT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_dout,
    output logic [DW-1:0] inst_data,
    output logic [AW-1:0] inst_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    output logic          busy,
    output logic          halted,
    output logic          pc_wrapped
);

    fetch_state_e  state_q;
    logic [DW-1:0] inst_data_q;
    logic [AW-1:0] inst_pc_q;
    logic          inst_valid_q;
    logic          busy_q;
    logic          halted_q;

    logic [AW-1:0] pc;
    logic          start_ok;
    logic          is_halt;
    logic          pc_load;
    logic [AW-1:0] pc_load_val;
    logic          pc_inc;

    always_comb begin
        start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));
        is_halt     = (inst_data_q[OP_LSB +: OP_W] == HALT_OP);
        pc_load     = start_ok ||
                      (redirect_valid && ((state_q == ST_FETCH) || (state_q == ST_ISSUE)));
        pc_load_val = start_ok ? RESET_PC : redirect_addr;
        // pc_inc also marks the cycles where the instruction register captures rom_dout
        pc_inc      = ((state_q == ST_FETCH) && !redirect_valid) ||
                      ((state_q == ST_ISSUE) && !redirect_valid && inst_ready && !is_halt);
    end

    fetch_pc #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (pc_inc),
        .clr_wrap_i (start_ok),
        .pc_o       (pc),
        .wrapped_o  (pc_wrapped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            if (pc_inc) begin
                inst_data_q <= rom_dout;
                inst_pc_q   <= pc;
            end
            unique case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_q  <= ST_FETCH;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (!redirect_valid) begin
                        state_q      <= ST_ISSUE;
                        inst_valid_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (redirect_valid) begin
                        state_q      <= ST_FETCH;
                        inst_valid_q <= 1'b0;
                    end else if (inst_ready && is_halt) begin
                        state_q      <= ST_HALT;
                        inst_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        halted_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr   = pc;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign busy       = busy_q;
    assign halted     = halted_q;

endmodule
